divider: RTL and testbench
==========================

Name: divider

Overview:
- Multi-cycle sequential restoring divider for the 8086 DIV/IDIV instructions.
- Sits beside the combinational ALU in the execute stage. The microcode sequencer starts it, waits on busy/complete, then writes the quotient and remainder back.
- Reports divide errors (divide by zero, quotient overflow) so microcode can vector to INT 0.

Parameters:
None. Widths are fixed by the ISA; the constants live in the package.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; accepted only when busy=0
- is_8_bit  input  1  1: 16/8 divide (AX / r8); 0: 32/16 divide (DX:AX / r16)
- is_signed  input  1  1: IDIV semantics; 0: DIV semantics
- dividend  input  32  8-bit mode uses [15:0] (AX), [31:16] ignored; 16-bit mode uses {DX,AX}
- divisor  input  16  8-bit mode uses [7:0]
- quotient  output  16  8-bit mode: [7:0]=AL, [15:8]=0
- remainder  output  16  8-bit mode: [7:0]=AH, [15:8]=0
- busy  output  1  high from the cycle after acceptance until complete
- complete  output  1  single-cycle pulse; results valid
- error  output  1  valid with complete; 1 = divide error

Behaviour:
- Reset: state=IDLE; busy, complete, error, quotient and remainder all 0. Reset mid-operation aborts with no complete pulse.
- Inputs are sampled only on the accepted start edge. start while busy is ignored.
- States: IDLE, INIT, DIVIDE, FIXUP, DONE.
- IDLE -> INIT on start.
- INIT:
  - Latch operand magnitudes (two's-complement negate when is_signed and the sign bit is set). Sign bits: dividend[15]/divisor[7] in 8-bit mode, dividend[31]/divisor[15] in 16-bit mode.
  - Record quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
  - If |divisor|==0, or the high half of |dividend| >= |divisor|: set error, go to DONE.
  - Otherwise load the iteration counter with N (8 or 16), go to DIVIDE.
- DIVIDE: one restoring step per cycle.
  - Shift {rem,quot} left; trial-subtract the divisor from rem; keep the result if non-negative and set the quotient LSB.
  - After N steps, go to FIXUP.
- FIXUP:
  - Apply signs (negate the quotient magnitude if its sign is set; negate the remainder magnitude if the dividend was negative).
  - Signed range check: the magnitude quotient must be <=0x7F (8-bit) or <=0x7FFF (16-bit), else error.
  - Go to DONE.
- DONE: complete=1 for exactly one cycle, busy=0, return to IDLE.
- Latency from the start cycle to the complete pulse:
  - 8-bit: N+3 = 11 cycles.
  - 16-bit: 19 cycles.
  - Early error from INIT: 2 cycles.
- On error, quotient=0 and remainder=0.
- quotient, remainder and error hold their values after complete until the next accepted start; they are cleared on acceptance.
- Remainder of zero is never negated to a non-zero value. Zero results are positive.
- Unsigned results are never sign-processed; the check for quotient > 0xFF/0xFFFF is fully covered by the INIT high-half test.

Optional Feature:
- DIVIDER_FULL_SIGNED_RANGE_EN
  - Defined: 80186 behaviour. Signed quotient magnitude 0x80 (8-bit) / 0x8000 (16-bit) is accepted when the quotient sign is negative, giving -128 / -32768.
  - Undefined: original 8086 behaviour. These cases raise error.
  - Unsigned behaviour and latency are unchanged either way.

Decomposition:
- Shared package holds:
  - DivState_t enum: IDLE, INIT, DIVIDE, FIXUP, DONE.
  - DIV_STEPS_8 = 8 and DIV_STEPS_16 = 16.
  - Signed range limit constants.
- One natural sub-module: divider_step. A combinational single restoring iteration: inputs partial remainder, next dividend bit, divisor; outputs new remainder and quotient bit. It is instantiated once in divider.

Test Plan:
1. Unsigned 8-bit, dividend 0x00000064, divisor 0x0007 -> quotient 0x000E, remainder 0x0002, error 0; complete exactly 11 cycles after start; busy high in the 10 cycles between.
2. Unsigned 16-bit, dividend 0x00010000, divisor 0x0003 -> quotient 0x5555, remainder 0x0001, complete at cycle 19. Then divisor 0x0002 with dividend 0x00020000 -> error 1, quotient/remainder 0, complete at cycle 2.
3. Divide by zero, 8-bit and 16-bit, signed and unsigned, divisor 0x0000 -> error 1 at cycle 2. A start issued while busy in a prior operation is ignored; that operation's results are unchanged.
4. Signed 8-bit, dividend 0x0000FF9C (-100), divisor 0x0007 -> quotient 0x00F2 (-14), remainder 0x00FE (-2). Signed 16-bit, 0xFFFFFF9C / 0xFFF9 -> quotient 0x000E, remainder 0xFFFE.
5. Signed 8-bit, dividend 0x0000FF80, divisor 0x0001 -> without macro: error 1. With DIVIDER_FULL_SIGNED_RANGE_EN: quotient 0x0080, remainder 0x0000, error 0. Dividend 0x00000080 / 0x0001 -> error 1 in both builds.
6. Assert reset at cycle 5 of a 16-bit divide -> busy/complete/outputs go to 0 immediately; no complete pulse; the next start runs normally to the correct result.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM states, iteration counts and signed range limits
// for the 8086 DIV/IDIV sequential divider.
// Configuration macro: DIVIDER_FULL_SIGNED_RANGE_EN (consumed by divider.sv).
package divider_pkg;

    localparam int unsigned DIV_STEPS_8  = 8;
    localparam int unsigned DIV_STEPS_16 = 16;
    localparam int unsigned CNT_W        = 5;

    // Largest positive signed quotient magnitude, and the one extra negative
    // magnitude that the full signed range accepts.
    localparam logic [15:0] SRANGE_POS_8  = 16'h007F;
    localparam logic [15:0] SRANGE_POS_16 = 16'h7FFF;
    localparam logic [15:0] SRANGE_NEG_8  = 16'h0080;
    localparam logic [15:0] SRANGE_NEG_16 = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DIVIDE,
        FIXUP,
        DONE
    } DivState_t;

    // Conditional two's-complement negate.
    function automatic logic [15:0] neg16(input logic n, input logic [15:0] x);
        return n ? (~x + 16'd1) : x;
    endfunction

    function automatic logic [31:0] neg32(input logic n, input logic [31:0] x);
        return n ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration.
// Ports:
//   i_rem     partial remainder (always < i_divisor on entry)
//   i_bit     next dividend bit shifted into the remainder
//   i_divisor divisor magnitude
//   o_rem     updated partial remainder
//   o_qbit    quotient bit produced by this iteration
module divider_step (
    input  logic [15:0] i_rem,
    input  logic        i_bit,
    input  logic [15:0] i_divisor,
    output logic [15:0] o_rem,
    output logic        o_qbit
);

    logic [16:0] w_shift;
    logic [15:0] w_diff;

    // Shifted remainder needs 17 bits; the difference always fits in 16 when kept.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift[15:0] - i_divisor;
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff : w_shift[15:0];

endmodule

// File: rtl/divider.sv
// divider: multi-cycle restoring divider for 8086 DIV/IDIV.
// Ports:
//   clk, reset (async, active-high)
//   start      request pulse, accepted when busy=0
//   is_8_bit   1: AX / r8, 0: DX:AX / r16
//   is_signed  1: IDIV, 0: DIV
//   dividend   [15:0] in 8-bit mode, full 32 bits in 16-bit mode
//   divisor    [7:0] in 8-bit mode, full 16 bits in 16-bit mode
//   quotient, remainder  results (upper byte 0 in 8-bit mode)
//   busy       high while an operation is in flight
//   complete   one-cycle pulse, results valid
//   error      divide error, valid with complete
// Configuration: define DIVIDER_FULL_SIGNED_RANGE_EN to accept quotients of
// -128 / -32768 (80186 behaviour); undefined gives 8086 behaviour.
module divider
    import divider_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);

    DivState_t          r_state;
    logic [31:0]        r_dvd_raw;
    logic [15:0]        r_dvs_raw;
    logic               r_is8;
    logic               r_signed;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [15:0]        r_dvs;
    logic [15:0]        r_rem;
    logic [15:0]        r_quot;
    logic [CNT_W-1:0]   r_count;

    logic               w_dvd_sign;
    logic               w_dvs_sign;
    logic [31:0]        w_dvd_full;
    logic [31:0]        w_dvd_neg;
    logic [31:0]        w_dvd_mag;
    logic [15:0]        w_dvs_full;
    logic [15:0]        w_dvs_neg;
    logic [15:0]        w_dvs_mag;
    logic [15:0]        w_hi;
    logic [15:0]        w_lo_aligned;
    logic               w_init_err;
    logic [15:0]        w_step_rem;
    logic               w_step_q;
    logic [15:0]        w_q_neg;
    logic [15:0]        w_r_neg;
    logic [15:0]        w_q_fix;
    logic [15:0]        w_r_fix;
    logic [15:0]        w_lim_pos;
    logic [15:0]        w_lim_neg;
    logic               w_neg_ok;
    logic               w_range_err;

    // Operand signs and magnitudes from the latched raw operands.
    assign w_dvd_sign = r_signed & (r_is8 ? r_dvd_raw[15] : r_dvd_raw[31]);
    assign w_dvs_sign = r_signed & (r_is8 ? r_dvs_raw[7] : r_dvs_raw[15]);
    assign w_dvd_full = r_is8 ? {16'h0000, r_dvd_raw[15:0]} : r_dvd_raw;
    assign w_dvs_full = r_is8 ? {8'h00, r_dvs_raw[7:0]} : r_dvs_raw;
    assign w_dvd_neg  = neg32(w_dvd_sign, w_dvd_full);
    assign w_dvs_neg  = neg16(w_dvs_sign, w_dvs_full);
    assign w_dvd_mag  = r_is8 ? {16'h0000, w_dvd_neg[15:0]} : w_dvd_neg;
    assign w_dvs_mag  = r_is8 ? {8'h00, w_dvs_neg[7:0]} : w_dvs_neg;

    // High half seeds the remainder; low half is left-aligned so the next
    // dividend bit is always r_quot[15] and quotient bits land at the bottom.
    assign w_hi         = r_is8 ? {8'h00, w_dvd_mag[15:8]} : w_dvd_mag[31:16];
    assign w_lo_aligned = r_is8 ? {w_dvd_mag[7:0], 8'h00} : w_dvd_mag[15:0];
    assign w_init_err   = (w_dvs_mag == 16'h0000) || (w_hi >= w_dvs_mag);

    divider_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[15]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Sign application, masked back to the operand width.
    assign w_q_neg = neg16(r_q_neg, r_quot);
    assign w_r_neg = neg16(r_r_neg, r_rem);
    assign w_q_fix = r_is8 ? {8'h00, w_q_neg[7:0]} : w_q_neg;
    assign w_r_fix = r_is8 ? {8'h00, w_r_neg[7:0]} : w_r_neg;

    // Signed range check on the quotient magnitude.
    assign w_lim_pos = r_is8 ? SRANGE_POS_8 : SRANGE_POS_16;
    assign w_lim_neg = r_is8 ? SRANGE_NEG_8 : SRANGE_NEG_16;
`ifdef DIVIDER_FULL_SIGNED_RANGE_EN
    assign w_neg_ok  = r_q_neg && (r_quot == w_lim_neg);
`else
    assign w_neg_ok  = 1'b0 & (r_quot == w_lim_neg);
`endif
    assign w_range_err = r_signed && (r_quot > w_lim_pos) && !w_neg_ok;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_dvd_raw <= 32'h0;
            r_dvs_raw <= 16'h0;
            r_is8     <= 1'b0;
            r_signed  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dvs     <= 16'h0;
            r_rem     <= 16'h0;
            r_quot    <= 16'h0;
            r_count   <= '0;
            quotient  <= 16'h0;
            remainder <= 16'h0;
            busy      <= 1'b0;
            complete  <= 1'b0;
            error     <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dvd_raw <= dividend;
                        r_dvs_raw <= divisor;
                        r_is8     <= is_8_bit;
                        r_signed  <= is_signed;
                        busy      <= 1'b1;
                        quotient  <= 16'h0;
                        remainder <= 16'h0;
                        error     <= 1'b0;
                        r_state   <= INIT;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                INIT: begin
                    r_q_neg <= w_dvd_sign ^ w_dvs_sign;
                    r_r_neg <= w_dvd_sign;
                    r_dvs   <= w_dvs_mag;
                    r_rem   <= w_hi;
                    r_quot  <= w_lo_aligned;
                    if (w_init_err) begin
                        busy     <= 1'b0;
                        complete <= 1'b1;
                        error    <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_count  <= r_is8 ? CNT_W'(DIV_STEPS_8) : CNT_W'(DIV_STEPS_16);
                        r_state  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    r_rem   <= w_step_rem;
                    r_quot  <= {r_quot[14:0], w_step_q};
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    busy     <= 1'b0;
                    complete <= 1'b1;
                    error    <= w_range_err;
                    quotient <= w_range_err ? 16'h0 : w_q_fix;
                    remainder <= w_range_err ? 16'h0 : w_r_fix;
                    r_state  <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for the DIV/IDIV divider. Expected results are
// queued when an operation is started and compared when complete pulses.
module tb_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        error;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;

    divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_8_bit  (is_8_bit),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model built on integer division (truncates toward zero).
    function automatic exp_t model(input logic is8, input logic sgn,
                                   input logic [31:0] dvd, input logic [15:0] dvs);
        exp_t   x;
        longint a, b, am, bm, qq, rr, lim_p, lim_n, mask;
        int     n;
        n = is8 ? 8 : 16;
        if (is8) begin
            a = longint'(dvd[15:0]);
            b = longint'(dvs[7:0]);
            if (sgn && dvd[15]) a = a - 65536;
            if (sgn && dvs[7])  b = b - 256;
        end else begin
            a = longint'(dvd);
            b = longint'(dvs);
            if (sgn && dvd[31]) a = a - 64'sd4294967296;
            if (sgn && dvs[15]) b = b - 65536;
        end
        am = (a < 0) ? -a : a;
        bm = (b < 0) ? -b : b;
        x.q = 16'h0; x.r = 16'h0; x.e = 1'b1; x.lat = 2;
        if (bm == 0) return x;
        if ((am / bm) >= (longint'(1) << n)) return x;
        qq = a / b;
        rr = a % b;
        x.lat = n + 3;
        lim_p = (longint'(1) << (n - 1)) - 1;
`ifdef DIVIDER_FULL_SIGNED_RANGE_EN
        lim_n = -(lim_p + 1);
`else
        lim_n = -lim_p;
`endif
        if (sgn && (qq > lim_p || qq < lim_n)) return x;
        mask = (longint'(1) << n) - 1;
        x.q = 16'(qq & mask);
        x.r = 16'(rr & mask);
        x.e = 1'b0;
        return x;
    endfunction

    // Run one operation; optionally pulse start again at cycle 'inject'.
    task automatic run_op(input string tag, input logic is8, input logic sgn,
                          input logic [31:0] dvd, input logic [15:0] dvs,
                          input exp_t ex, input int inject);
        exp_t got_exp;
        int   lat;
        int   busy_cnt;
        sb_q.push_back(ex);
        @(negedge clk);
        is_8_bit  = is8;
        is_signed = sgn;
        dividend  = dvd;
        divisor   = dvs;
        start     = 1'b1;
        lat = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start     = 1'b0;
            dividend  = $urandom;
            divisor   = 16'($urandom);
            is_8_bit  = ~is8;
            is_signed = ~sgn;
            if (c == 1) begin
                check({tag, ".clr"}, {quotient, remainder}, 32'h0);
            end
            if (c == inject) begin
                dividend = 32'h0000_0001;
                divisor  = 16'h0001;
                start    = 1'b1;
            end
            if (complete) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        got_exp = sb_q.pop_front();
        if (lat == 0) begin
            check({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, ".q"},    32'(quotient),  32'(got_exp.q));
            check({tag, ".r"},    32'(remainder), 32'(got_exp.r));
            check({tag, ".err"},  32'(error),     32'(got_exp.e));
            check({tag, ".lat"},  32'(lat),       32'(got_exp.lat));
            check({tag, ".busy"}, 32'(busy_cnt),  32'(got_exp.lat - 1));
        end
    endtask

    function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                                input logic e, input int lat);
        exp_t x;
        x.q = q; x.r = r; x.e = e; x.lat = lat;
        return x;
    endfunction

    initial begin
        int          cpl_cnt;
        logic        r_is8;
        logic        r_sgn;
        logic [31:0] r_dvd;
        logic [15:0] r_dvs;

        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_8_bit  = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0;
        divisor   = 16'h0;
        repeat (2) @(negedge clk);
        check("rst.outs", {quotient, remainder}, 32'h0);
        check("rst.flags", {29'h0, busy, complete, error}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic unsigned cases
        run_op("u8_100_7", 1'b1, 1'b0, 32'h0000_0064, 16'h0007, mk(16'h000E, 16'h0002, 1'b0, 11), 0);
        repeat (3) @(negedge clk);
        check("hold.q", 32'(quotient), 32'h0000_000E);
        run_op("u16_10000_3", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, mk(16'h5555, 16'h0001, 1'b0, 19), 0);
        run_op("u16_ovf", 1'b0, 1'b0, 32'h0002_0000, 16'h0002, mk(16'h0, 16'h0, 1'b1, 2), 0);

        // Divide by zero in every mode
        run_op("dz_u8",  1'b1, 1'b0, 32'h0000_1234, 16'h0000, mk(16'h0, 16'h0, 1'b1, 2), 0);
        run_op("dz_s8",  1'b1, 1'b1, 32'h0000_FF9C, 16'h0000, mk(16'h0, 16'h0, 1'b1, 2), 0);
        run_op("dz_u16", 1'b0, 1'b0, 32'h0000_1234, 16'h0000, mk(16'h0, 16'h0, 1'b1, 2), 0);
        run_op("dz_s16", 1'b0, 1'b1, 32'hFFFF_FF9C, 16'h0000, mk(16'h0, 16'h0, 1'b1, 2), 0);

        // Start while busy is ignored
        run_op("inject", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, mk(16'h5555, 16'h0001, 1'b0, 19), 5);
        @(negedge clk);
        check("inject.idle", 32'(busy), 32'h0);

        // Signed cases
        run_op("s8_neg100_7", 1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, mk(16'h00F2, 16'h00FE, 1'b0, 11), 0);
        run_op("s16_neg_neg", 1'b0, 1'b1, 32'hFFFF_FF9C, 16'hFFF9, mk(16'h000E, 16'hFFFE, 1'b0, 19), 0);
        run_op("s8_rem0",     1'b1, 1'b1, 32'h0000_FF9E, 16'h0007, mk(16'h00F2, 16'h0000, 1'b0, 11), 0);

        // Signed range boundaries
`ifdef DIVIDER_FULL_SIGNED_RANGE_EN
        run_op("s8_m128",   1'b1, 1'b1, 32'h0000_FF80, 16'h0001, mk(16'h0080, 16'h0000, 1'b0, 11), 0);
        run_op("s16_m32768", 1'b0, 1'b1, 32'hFFFF_8000, 16'h0001, mk(16'h8000, 16'h0000, 1'b0, 19), 0);
`else
        run_op("s8_m128",   1'b1, 1'b1, 32'h0000_FF80, 16'h0001, mk(16'h0, 16'h0, 1'b1, 11), 0);
        run_op("s16_m32768", 1'b0, 1'b1, 32'hFFFF_8000, 16'h0001, mk(16'h0, 16'h0, 1'b1, 19), 0);
`endif
        run_op("s8_p128", 1'b1, 1'b1, 32'h0000_0080, 16'h0001, mk(16'h0, 16'h0, 1'b1, 11), 0);

        // Reset in the middle of a 16-bit divide
        @(negedge clk);
        is_8_bit  = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0001_0000;
        divisor   = 16'h0003;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.flags", {29'h0, busy, complete, error}, 32'h0);
        check("midrst.outs", {quotient, remainder}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cpl_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (complete || busy) cpl_cnt++;
        end
        check("midrst.quiet", 32'(cpl_cnt), 32'h0);
        run_op("after_rst", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, mk(16'h5555, 16'h0001, 1'b0, 19), 0);

        // Randomized operations against the integer model
        for (int i = 0; i < 12; i++) begin
            r_is8 = 1'($urandom);
            r_sgn = 1'($urandom);
            r_dvs = 16'($urandom);
            r_dvd = $urandom;
            if (i % 2 == 0) r_dvd = r_dvd >> (r_is8 ? 20 : 12);
            run_op($sformatf("rnd%0d", i), r_is8, r_sgn, r_dvd, r_dvs,
                   model(r_is8, r_sgn, r_dvd, r_dvs), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
